lfsr_encrypter: RTL and testbench

Hardware encrypter for the lab 5 LFSR cipher; the transmit end of the decrypter's stream. On a start pulse it reads a plaintext message from data memory at addresses 0 and up. It prepends a preamble of underscore characters (8'h5f), XORs every byte with a 6-bit LFSR keystream built from a selected tap pattern and seed, and writes the 64-byte ciphertext block to addresses 64–127. It shares the single-port-write / combinational-read dat_mem with the rest of the design.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_encrypter_if.sv | 26 ++
 rtl/lfsr_encrypter_lfsr6b.sv | 36 +++
 rtl/lfsr_encrypter.sv | 142 ++++++++++++++
 tb/tb_lfsr_encrypter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the lab 5 LFSR cipher: tap table, preamble character,
// FSM state type and the LFSR step function.
package lfsr_pkg;

    localparam logic [5:0] LFSR_PTRN [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
    localparam logic [7:0] PAD_CHAR = 8'h5f;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    // Shift left, feeding back the parity of the tapped bits into bit 0.
    function automatic logic [5:0] lfsr_next(input logic [5:0] cur, input logic [5:0] taps);
        return {cur[4:0], ^(cur & taps)};
    endfunction

endpackage

// File: rtl/lfsr_encrypter_if.sv
// Data memory port shared by the encrypter: combinational read, single write.
interface lfsr_encrypter_if;

    logic [7:0] raddr;
    logic [7:0] data_out;
    logic [7:0] waddr;
    logic       wr_en;
    logic [7:0] data_in;

    modport master (
        output raddr,
        input  data_out,
        output waddr,
        output wr_en,
        output data_in
    );

    modport slave (
        input  raddr,
        output data_out,
        input  waddr,
        input  wr_en,
        input  data_in
    );

endinterface

// File: rtl/lfsr_encrypter_lfsr6b.sv
// 6-bit Fibonacci-style LFSR with synchronous load (init) and step enable (en).
module lfsr6b
    import lfsr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       en,
    input  logic [5:0] taps,
    input  logic [5:0] seed,
    output logic [5:0] q
);

    logic [5:0] state_q;
    logic [5:0] state_d;

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = seed;
        end else if (en) begin
            state_d = lfsr_next(state_q, taps);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/lfsr_encrypter.sv
// LFSR cipher encrypter: preamble + message XOR keystream, written to OUT_BASE.
// Optional ENC_PARITY_EN replaces bit 7 of each written byte with even parity.
module lfsr_encrypter
    import lfsr_pkg::*;
#(
    parameter int OUT_BASE = 64,
    parameter int BLK_LEN  = 64
) (
    input  logic                    clk,
    input  logic                    init_n,
    input  logic                    start,
    input  logic [2:0]              tap_sel,
    input  logic [5:0]              seed,
    input  logic [5:0]              pre_len,
    lfsr_encrypter_if.master        mem,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [7:0] BASE   = 8'(OUT_BASE);
    localparam logic [6:0] K_LAST = 7'(BLK_LEN - 1);

    state_t     state_q,   state_d;
    logic [6:0] k_q,       k_d;
    logic [2:0] tap_sel_q, tap_sel_d;
    logic [5:0] seed_q,    seed_d;
    logic [5:0] pre_len_q, pre_len_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;
    logic       err_q,     err_d;

    logic [5:0] lfsr_q;
    logic [5:0] taps;
    logic       run;
    logic       in_pre;
    logic [6:0] rd_off;
    logic [7:0] plain;
    logic [7:0] cipher;
    logic [7:0] cipher_out;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        tap_sel_d = tap_sel_q;
        seed_d    = seed_q;
        pre_len_d = pre_len_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (tap_sel > 3'd5 || seed == 6'd0) begin
                        err_d = 1'b1;
                    end else begin
                        tap_sel_d = tap_sel;
                        seed_d    = seed;
                        pre_len_d = pre_len;
                        busy_d    = 1'b1;
                        state_d   = LOAD;
                    end
                end
            end
            LOAD: begin
                k_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                k_d = k_q + 7'd1;
                if (k_q == K_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            tap_sel_q <= '0;
            seed_q    <= '0;
            pre_len_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            tap_sel_q <= tap_sel_d;
            seed_q    <= seed_d;
            pre_len_q <= pre_len_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign taps = LFSR_PTRN[tap_sel_q];

    lfsr6b u_lfsr (
        .clk   (clk),
        .rst_n (init_n),
        .init  (state_q == LOAD),
        .en    (state_q == RUN),
        .taps  (taps),
        .seed  (seed_q),
        .q     (lfsr_q)
    );

    assign run    = (state_q == RUN);
    assign in_pre = (k_q < {1'b0, pre_len_q});
    assign rd_off = k_q - {1'b0, pre_len_q};
    assign plain  = in_pre ? PAD_CHAR : mem.data_out;
    assign cipher = plain ^ {2'b00, lfsr_q};

`ifdef ENC_PARITY_EN
    // cipher[7] ^ (^cipher) equals ^cipher[6:0], giving even parity over the byte.
    assign cipher_out = {cipher[7] ^ (^cipher), cipher[6:0]};
`else
    assign cipher_out = cipher;
`endif

    assign mem.raddr   = (run && !in_pre) ? {1'b0, rd_off} : 8'd0;
    assign mem.waddr   = run ? (BASE + {1'b0, k_q}) : 8'd0;
    assign mem.wr_en   = run;
    assign mem.data_in = run ? cipher_out : 8'd0;

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_lfsr_encrypter.sv
// Scoreboard bench for lfsr_encrypter: a reference keystream model queues expected
// writes, a negedge monitor pops and compares every memory write the DUT makes.
module tb_lfsr_encrypter;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    localparam logic [5:0] TB_TAPS [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
`ifdef ENC_PARITY_EN
    localparam logic [7:0] CMP_MASK = 8'h7f;
`else
    localparam logic [7:0] CMP_MASK = 8'hff;
`endif

    logic       clk = 1'b0;
    logic       init_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] tap_sel = 3'd0;
    logic [5:0] seed = 6'd0;
    logic [5:0] pre_len = 6'd0;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] mem [256];
    wr_t        exp_q [$];
    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;

    lfsr_encrypter_if bus ();

    lfsr_encrypter dut (
        .clk     (clk),
        .init_n  (init_n),
        .start   (start),
        .tap_sel (tap_sel),
        .seed    (seed),
        .pre_len (pre_len),
        .mem     (bus),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    assign bus.data_out = mem[bus.raddr];

    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.waddr] <= bus.data_in;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    function automatic logic [7:0] enc(input logic [7:0] b);
`ifdef ENC_PARITY_EN
        return {^b[6:0], b[6:0]};
`else
        return b;
`endif
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Queue the first nwr ciphertext writes of a run from the plaintext in mem.
    task automatic push_run(input logic [2:0] ts, input logic [5:0] sd,
                            input logic [5:0] pl, input int nwr);
        logic [5:0] l;
        logic [7:0] p;
        wr_t        w;
        l = sd;
        for (int k = 0; k < 64; k++) begin
            if (k < int'(pl)) p = 8'h5f;
            else              p = mem[8'(k - int'(pl))];
            w.addr = 8'(64 + k);
            w.data = enc(p ^ {2'b00, l});
            if (k < nwr) exp_q.push_back(w);
            l = {l[4:0], ^(l & TB_TAPS[ts])};
        end
    endtask

    // Pulse start with the given settings; n returns posedges until done (200 = timeout).
    task automatic apply_stimulus(input logic [2:0] ts, input logic [5:0] sd,
                                  input logic [5:0] pl, output int n);
        @(posedge clk);
        #1;
        tap_sel = ts;
        seed    = sd;
        pre_len = pl;
        start   = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done) break;
        end
        if (!done) n = 200;
    endtask

    initial begin : monitor
        wr_t w;
        forever begin
            @(negedge clk);
            if (bus.wr_en) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: actual addr=%0h data=%0h required no write",
                             bus.waddr, bus.data_in);
                end else begin
                    w = exp_q.pop_front();
                    check_output("wr_addr", {24'd0, bus.waddr}, {24'd0, w.addr});
                    check_output("wr_data", {24'd0, bus.data_in}, {24'd0, w.data});
                end
            end
        end
    end

    initial begin : stim
        int n;
        int d0;
        int untouched_bad;
        logic [2:0] ts_tab [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2};
        logic [5:0] sd_tab [6] = '{6'h2A, 6'h15, 6'h3F, 6'h07, 6'h30, 6'h09};
        logic [5:0] pl_tab [6] = '{6'd10, 6'd12, 6'd7, 6'd10, 6'd12, 6'd0};

        for (int i = 0; i < 256; i++) mem[i] = (i < 64) ? 8'(8'h48 + i) : 8'h00;

        #12;
        check_output("rst_busy",  {31'd0, busy}, 32'd0);
        check_output("rst_done",  {31'd0, done}, 32'd0);
        check_output("rst_err",   {31'd0, err}, 32'd0);
        check_output("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check_output("rst_waddr", {24'd0, bus.waddr}, 32'd0);
        check_output("rst_raddr", {24'd0, bus.raddr}, 32'd0);
        check_output("rst_data_in", {24'd0, bus.data_in}, 32'd0);
        @(negedge clk);
        init_n = 1'b1;

        $display("[TB] directed run: seed=01 tap_sel=0 pre_len=7");
        push_run(3'd0, 6'h01, 6'd7, 64);
        apply_stimulus(3'd0, 6'h01, 6'd7, n);
        check_output("done_latency", n, 66);
        repeat (2) @(negedge clk);
        check_output("mem64", {24'd0, mem[64] & CMP_MASK}, {24'd0, 8'h5e & CMP_MASK});
        check_output("mem65", {24'd0, mem[65] & CMP_MASK}, {24'd0, 8'h5c & CMP_MASK});
        check_output("mem66", {24'd0, mem[66] & CMP_MASK}, {24'd0, 8'h58 & CMP_MASK});
        check_output("mem70", {24'd0, mem[70] & CMP_MASK}, {24'd0, 8'h61 & CMP_MASK});
        check_output("mem71", {24'd0, mem[71] & CMP_MASK}, {24'd0, 8'h75 & CMP_MASK});
`ifdef ENC_PARITY_EN
        check_output("parity64", {31'd0, ^mem[64]}, 32'd0);
`endif

        $display("[TB] tap and preamble sweep");
        for (int i = 0; i < 6; i++) begin
            push_run(ts_tab[i], sd_tab[i], pl_tab[i], 64);
            apply_stimulus(ts_tab[i], sd_tab[i], pl_tab[i], n);
            check_output("sweep_latency", n, 66);
            repeat (2) @(negedge clk);
        end
        check_output("prelen0_mem64", {24'd0, mem[64] & CMP_MASK}, {24'd0, 8'h41 & CMP_MASK});

        $display("[TB] rejection");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            tap_sel = (i == 0) ? 3'd0 : 3'd6;
            seed    = (i == 0) ? 6'd0 : 6'h05;
            start   = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check_output("err_pulse", {31'd0, err}, 32'd1);
            check_output("err_busy",  {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
            check_output("err_clear", {31'd0, err}, 32'd0);
            check_output("err_busy2", {31'd0, busy}, 32'd0);
        end

        $display("[TB] start during run");
        d0 = done_cnt;
        push_run(3'd1, 6'h11, 6'd10, 64);
        @(posedge clk);
        #1;
        tap_sel = 3'd1;
        seed    = 6'h11;
        pre_len = 6'd10;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        tap_sel = 3'd3;
        seed    = 6'h22;
        pre_len = 6'd5;
        start   = 1'b1;
        check_output("busy_mid_run", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (n < 200 && !done) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("restart_done_seen", {31'd0, done}, 32'd1);
        repeat (10) @(negedge clk);
        check_output("single_done", done_cnt - d0, 1);
        check_output("restart_queue_empty", exp_q.size(), 0);

        $display("[TB] reset mid-run");
        for (int i = 64; i < 128; i++) mem[i] = 8'hA5;
        push_run(3'd4, 6'h1B, 6'd12, 20);
        @(posedge clk);
        #1;
        tap_sel = 3'd4;
        seed    = 6'h1B;
        pre_len = 6'd12;
        start   = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (exp_q.size() == 0) break;
        end
        check_output("k20_waddr", {24'd0, bus.waddr}, 32'd84);
        init_n = 1'b0;
        #1;
        check_output("async_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check_output("async_busy",  {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        init_n = 1'b1;
        untouched_bad = 0;
        for (int i = 84; i < 128; i++) if (mem[i] !== 8'hA5) untouched_bad++;
        check_output("untouched_count", untouched_bad, 0);
        push_run(3'd5, 6'h2C, 6'd7, 64);
        apply_stimulus(3'd5, 6'h2C, 6'd7, n);
        check_output("post_reset_latency", n, 66);

        repeat (5) @(negedge clk);
        check_output("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
